corr_accel_resp: RTL

- Memory-mapped complex-correlation accelerator and result-buffer responder on the sigma SoC bus.
- Accepts interleaved two-stream complex samples and keeps a sliding window of WIND_SIZE samples per stream.
- For every window position it accumulates a·conj(b) over all ordered pairs of the 2·WIND_SIZE window entries into 21 real/imag accumulators.
- Serves the accumulators to CPU/UDM read requests at the result-buffer offsets.

---
 rtl/corr_accel_pkg.sv | 36 +++
 rtl/corr_accel_resp_if.sv | 24 ++
 rtl/corr_accel_mac.sv | 32 +++
 rtl/corr_accel_resp.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/corr_accel_pkg.sv
// Shared types and constants for the complex-correlation accelerator:
// sample layout, register map, FSM encoding and window geometry.
package corr_accel_pkg;

  localparam int WIND_SIZE    = 3;
  localparam int INTEG_LENGTH = 10;
  localparam int ACC_W        = 32;

  localparam logic [11:0] CTRL_ADDR   = 12'h000;
  localparam logic [11:0] SAMPLE_ADDR = 12'h004;
  localparam logic [11:0] RES_OFFSET  = 12'h100;

  localparam int N_DEPTH   = 2 * WIND_SIZE;
  localparam int N_WINDOWS = INTEG_LENGTH - WIND_SIZE + 1;

  // Number of ordered pairs (j <= k) over the 2*w window entries.
  function automatic int n_entries(input int w);
    return w * (2 * w + 1);
  endfunction

  localparam int N_ENTRIES = n_entries(WIND_SIZE);

  typedef struct packed {
    logic signed [7:0] im;
    logic signed [7:0] re;
  } cplx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT,
    S_CALC,
    S_DONE
  } state_e;

endpackage

// File: rtl/corr_accel_resp_if.sv
// Host bus of the accelerator: single-cycle request/ack with a registered
// read response one cycle after the ack.
interface corr_accel_resp_if;

  logic        host_req_i;
  logic        host_ack_o;
  logic        host_we_i;
  logic [11:0] host_addr_i;
  logic [3:0]  host_be_i;
  logic [31:0] host_wdata_i;
  logic        host_resp_o;
  logic [31:0] host_rdata_o;

  modport master (
    output host_req_i, host_we_i, host_addr_i, host_be_i, host_wdata_i,
    input  host_ack_o, host_resp_o, host_rdata_o
  );

  modport slave (
    input  host_req_i, host_we_i, host_addr_i, host_be_i, host_wdata_i,
    output host_ack_o, host_resp_o, host_rdata_o
  );

endinterface

// File: rtl/corr_accel_mac.sv
// Registered complex multiply a * conj(b), operands sign-extended to ACC_W.
// One cycle of latency; the caller tracks the destination index.
module corr_accel_mac
  import corr_accel_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  cplx_t                   i_a,
  input  cplx_t                   i_b,
  output logic signed [ACC_W-1:0] o_re,
  output logic signed [ACC_W-1:0] o_im
);

  logic signed [ACC_W-1:0] w_ra, w_ia, w_rb, w_ib;

  assign w_ra = {{(ACC_W-8){i_a.re[7]}}, i_a.re};
  assign w_ia = {{(ACC_W-8){i_a.im[7]}}, i_a.im};
  assign w_rb = {{(ACC_W-8){i_b.re[7]}}, i_b.re};
  assign w_ib = {{(ACC_W-8){i_b.im[7]}}, i_b.im};

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      o_re <= '0;
      o_im <= '0;
    end else begin
      o_re <= w_ra * w_rb + w_ia * w_ib;
      o_im <= w_ia * w_rb - w_ra * w_ib;
    end
  end

endmodule

// File: rtl/corr_accel_resp.sv
// Sliding-window complex-correlation accelerator: collects two sample streams,
// accumulates a*conj(b) over every window pair and serves results to the host.
module corr_accel_resp
  import corr_accel_pkg::*;
(
  input  logic              clk_i,
  input  logic              arst_i,
  corr_accel_resp_if.slave  bus,
  output logic              done_o
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int SEL_W = $clog2(N_DEPTH);

  state_e                  r_state, w_next_state;
  cplx_t                   r_win    [N_DEPTH];
  logic signed [ACC_W-1:0] r_acc_re [N_ENTRIES];
  logic signed [ACC_W-1:0] r_acc_im [N_ENTRIES];
  logic [7:0]              r_push_cnt, r_win_cnt;
  logic [IDX_W-1:0]        r_cnt, r_acc_idx;
  logic [SEL_W-1:0]        r_j, r_k;
  logic                    r_acc_vld;
  logic                    r_resp;
  logic [31:0]             r_rdata;

  logic                    w_busy, w_done, w_ack, w_clear, w_push, w_rd, w_last_mac;
  logic                    w_is_ctrl, w_is_sample, w_in_res;
  logic [11:0]             w_off;
  logic [31:0]             w_rdata;
  logic signed [ACC_W-1:0] w_p_re, w_p_im;
  logic                    w_unused_be;

  assign w_unused_be = ^bus.host_be_i;

  assign w_is_ctrl   = (bus.host_addr_i == CTRL_ADDR);
  assign w_is_sample = (bus.host_addr_i == SAMPLE_ADDR);

  // Only a SAMPLE write is stalled during CALC; CTRL clears must abort at once.
  assign w_ack      = bus.host_req_i && !(w_busy && bus.host_we_i && w_is_sample);
  assign w_clear    = w_ack && bus.host_we_i && w_is_ctrl && bus.host_wdata_i[0];
  assign w_push     = w_ack && bus.host_we_i && w_is_sample &&
                      (r_state == S_FILL || r_state == S_WAIT);
  assign w_rd       = w_ack && !bus.host_we_i;
  assign w_last_mac = (r_state == S_CALC) && (r_cnt == IDX_W'(N_ENTRIES - 1));

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    if (w_clear) begin
      w_next_state = S_FILL;
    end else begin
      case (r_state)
        S_IDLE: w_next_state = S_FILL;
        S_FILL: if (w_push && r_push_cnt == 8'(WIND_SIZE - 1)) w_next_state = S_CALC;
        S_WAIT: if (w_push) w_next_state = S_CALC;
        S_CALC: if (w_last_mac)
                  w_next_state = (r_win_cnt == 8'(N_WINDOWS - 1)) ? S_DONE : S_WAIT;
        S_DONE: w_next_state = S_DONE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_CALC:  w_busy = 1'b1;
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < N_DEPTH; i++) r_win[i] <= '0;
      r_push_cnt <= '0;
      r_win_cnt  <= '0;
      r_cnt      <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_acc_vld  <= 1'b0;
      r_acc_idx  <= '0;
    end else if (w_clear) begin
      for (int i = 0; i < N_DEPTH; i++) r_win[i] <= '0;
      r_push_cnt <= '0;
      r_win_cnt  <= '0;
      r_cnt      <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_acc_vld  <= 1'b0;
      r_acc_idx  <= '0;
    end else begin
      if (w_push) begin
        for (int i = 0; i < WIND_SIZE - 1; i++) begin
          r_win[i]             <= r_win[i+1];
          r_win[WIND_SIZE + i] <= r_win[WIND_SIZE + i + 1];
        end
        r_win[WIND_SIZE-1] <= cplx_t'(bus.host_wdata_i[15:0]);
        r_win[N_DEPTH-1]   <= cplx_t'(bus.host_wdata_i[31:16]);
        r_push_cnt         <= r_push_cnt + 8'd1;
      end
      // The product lands one cycle after issue, so the index rides along.
      r_acc_vld <= (r_state == S_CALC);
      r_acc_idx <= r_cnt;
      if (r_state == S_CALC) begin
        if (w_last_mac) begin
          r_cnt     <= '0;
          r_j       <= '0;
          r_k       <= '0;
          r_win_cnt <= r_win_cnt + 8'd1;
        end else begin
          r_cnt <= r_cnt + IDX_W'(1);
          if (r_k == SEL_W'(N_DEPTH - 1)) begin
            r_j <= r_j + SEL_W'(1);
            r_k <= r_j + SEL_W'(1);
          end else begin
            r_k <= r_k + SEL_W'(1);
          end
        end
      end
    end
  end

  corr_accel_mac u_mac (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .i_a    (r_win[r_j]),
    .i_b    (r_win[r_k]),
    .o_re   (w_p_re),
    .o_im   (w_p_im)
  );

  // NOTE: the accumulator array is reset explicitly because results must read 0 after reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        r_acc_re[i] <= '0;
        r_acc_im[i] <= '0;
      end
    end else if (w_clear) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        r_acc_re[i] <= '0;
        r_acc_im[i] <= '0;
      end
    end else if (r_acc_vld) begin
      r_acc_re[r_acc_idx] <= r_acc_re[r_acc_idx] + w_p_re;
      r_acc_im[r_acc_idx] <= r_acc_im[r_acc_idx] + w_p_im;
    end
  end

  assign w_off    = bus.host_addr_i - RES_OFFSET;
  assign w_in_res = (bus.host_addr_i >= RES_OFFSET) &&
                    (w_off < 12'(8 * N_ENTRIES)) &&
                    (bus.host_addr_i[1:0] == 2'b00);

  always_comb begin
    w_rdata = '0;
    if (w_is_ctrl)
      w_rdata = {16'h0000, r_win_cnt, 6'b000000, w_done, w_busy};
    else if (w_in_res)
      w_rdata = w_off[2] ? r_acc_im[w_off[7:3]] : r_acc_re[w_off[7:3]];
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_resp  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_resp  <= w_rd;
      r_rdata <= w_rd ? w_rdata : '0;
    end
  end

  assign bus.host_ack_o   = w_ack;
  assign bus.host_resp_o  = r_resp;
  assign bus.host_rdata_o = r_rdata;
  assign done_o           = w_done;

endmodule
